pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Arbiter sharing the single physical-memory line port between the instruction cache and the data cache. Sits between the two cache instances' pmem-side interfaces and main memory. It grants one cache at a time, routes its read/write request, address and write line to memory, and routes the response back to that cache only. Transactions are whole-line and non-overlapping; each granted transaction ends on `mem_resp`.

## Interface
- `LINE_WIDTH`, 256, cache line width in bits (pmem data width)
- `ADDR_WIDTH`, 32, line address width
- `clk` in 1: the single clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `i_pmem_read` in 1: I-cache line read request
- `i_pmem_addr` in ADDR_WIDTH: I-cache request address
- `i_pmem_rdata` out LINE_WIDTH: line data to I-cache
- `i_pmem_resp` out 1: I-cache transaction complete
- `d_pmem_read` in 1: D-cache line read request
- `d_pmem_write` in 1: D-cache line write-back request
- `d_pmem_addr` in ADDR_WIDTH: D-cache request address
- `d_pmem_wdata` in LINE_WIDTH: D-cache write-back line
- `d_pmem_rdata` out LINE_WIDTH: line data to D-cache
- `d_pmem_resp` out 1: D-cache transaction complete
- `mem_read` out 1: read request to memory
- `mem_write` out 1: write request to memory
- `mem_addr` out ADDR_WIDTH: memory address
- `mem_wdata` out LINE_WIDTH: memory write line
- `mem_rdata` in LINE_WIDTH: memory read line
- `mem_resp` in 1: memory transaction complete

## Operation
- States: IDLE, I_BUSY, D_BUSY. Also a `last_grant` register: 0 = I, 1 = D.
- IDLE
  - `mem_read`, `mem_write` and both `*_resp` outputs are 0.
  - Grant is decided from the requests sampled at the clock edge.
  - D-only request → D_BUSY. I-only request → I_BUSY.
  - Both request → priority rule (see Configuration).
  - On entering a busy state, `last_grant` is updated to the granted side.
- I_BUSY
  - `mem_read` = `i_pmem_read`; `mem_write` = 0; `mem_addr` = `i_pmem_addr`.
  - `i_pmem_resp` = `mem_resp`.
  - On `mem_resp` → IDLE.
- D_BUSY
  - `mem_addr` = `d_pmem_addr`; `mem_wdata` = `d_pmem_wdata`.
  - `mem_write` = `d_pmem_write`; `mem_read` = `d_pmem_read & ~d_pmem_write`. Write wins if both are asserted.
  - `d_pmem_resp` = `mem_resp`.
  - On `mem_resp` → IDLE.
- Data routing: `i_pmem_rdata` and `d_pmem_rdata` are both wired straight to `mem_rdata`. Only the resp signal is gated, so a cache must qualify data with its own resp.
- The ungranted cache always sees resp = 0; its request stays pending with no timeout.
- `mem_resp` while in IDLE is ignored and causes no state change.
- A D-cache write-back followed by a refill is two separate grants. The I-cache may win between them under the round-robin rule.
- `mem_wdata` = `d_pmem_wdata` in all states; it is don't-care unless `mem_write` = 1.
- `mem_addr` = `i_pmem_addr` in IDLE and I_BUSY.

## Timing
- Reset (async, `rst_n` = 0): state = IDLE, `last_grant` = 0.
  - `mem_read` = `mem_write` = `i_pmem_resp` = `d_pmem_resp` = 0 immediately, without waiting for a clock edge.
  - Reset during a busy state abandons the transaction; no resp is delivered.
- Grant latency: request asserted at edge N → state is busy after edge N → `mem_read`/`mem_write` asserted in cycle N+1.
- All outputs are combinational from the registered state plus the pass-through inputs. There is no comb path from `mem_resp` to `mem_read`/`mem_write`.
- Completion: `*_resp` is high in the same cycle as `mem_resp`.
- Exactly one IDLE bubble cycle follows every transaction.
- Minimum back-to-back transaction spacing is one idle cycle plus memory latency.

## Configuration
- Macro `PMEM_ARB_ROUND_ROBIN_EN`.
- Defined: on simultaneous I and D requests in IDLE, grant the side opposite `last_grant`.
- Undefined: on simultaneous requests, always grant D. The `last_grant` register is still present, but it does not affect the grant.

## Test plan
- Reset mid-transaction
  - Stimulus: in D_BUSY with `d_pmem_write` = 1, pull `rst_n` low between edges.
  - Required: `mem_write` drops to 0 the same cycle. After release, state is IDLE; a later `mem_resp` is ignored (no `*_resp`).
- Single I read
  - Stimulus: `i_pmem_read` = 1, `i_pmem_addr` = 0x0000_1000; memory responds 3 cycles after `mem_read`.
  - Required: `mem_addr` = 0x0000_1000. `i_pmem_resp` = 1 for exactly one cycle with `mem_rdata`. `d_pmem_resp` stays 0. One IDLE cycle follows.
- D write-back then refill
  - Stimulus: `d_pmem_write` to 0x0000_2000 with `wdata` = 256'hA5…A5, then `d_pmem_read` to 0x0000_3000.
  - Required: `mem_write` with the correct line, then one IDLE cycle, then `mem_read` to 0x0000_3000. Two `d_pmem_resp` pulses.
- Simultaneous requests with the macro defined, `last_grant` = D
  - Stimulus: I and D request in the same cycle.
  - Required: I is granted first, then D.
- Same simultaneous requests with the macro undefined
  - Required: D is granted first.
- Stray inputs
  - Stimulus: `mem_resp` pulsed while in IDLE; `d_pmem_read` & `d_pmem_write` both asserted while in D_BUSY.
  - Required: the `mem_resp` pulse causes no state change and no `*_resp`. With both D requests high, `mem_write` = 1 and `mem_read` = 0.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Shares one pmem line port between I-cache and D-cache; grant one cycle after request, resp same cycle as mem_resp.
// Ungranted side waits indefinitely (resp held 0); define PMEM_ARB_ROUND_ROBIN_EN for round-robin ties, else D wins.
module pmem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   i_req, d_req, tie_grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // On a tie, hand the port to whichever side did not have it last.
  assign tie_grant_d = ~last_grant;
`else
  assign tie_grant_d = 1'b1;
`endif

  // Read data is broadcast; caches qualify it with their own resp.
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign mem_wdata    = d_pmem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = i_pmem_addr;
    i_pmem_resp    = 1'b0;
    d_pmem_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || tie_grant_d)) begin
          state_nxt      = D_BUSY;
          last_grant_nxt = 1'b1;
        end else if (i_req) begin
          state_nxt      = I_BUSY;
          last_grant_nxt = 1'b0;
        end
      end
      I_BUSY: begin
        mem_read    = i_pmem_read;
        i_pmem_resp = mem_resp;
        if (mem_resp) state_nxt = IDLE;
      end
      D_BUSY: begin
        mem_addr    = d_pmem_addr;
        mem_write   = d_pmem_write;
        mem_read    = d_pmem_read & ~d_pmem_write;
        d_pmem_resp = mem_resp;
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed per-cycle vector table for pmem_arbiter plus a hand-written async reset sequence.
module tb_pmem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam logic [AW-1:0] IA = 32'h0000_1000;
  localparam logic [AW-1:0] DA = 32'h0000_2000;
  localparam logic [AW-1:0] DB = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_addr;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read, d_pmem_write;
  logic [AW-1:0] d_pmem_addr;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    logic          rst_n, ird, drd, dwr, resp;
    logic [AW-1:0] daddr;
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic r, ird, drd, dwr, resp, input logic [AW-1:0] daddr,
                     input logic e_rd, e_wr, e_ir, e_dr, input logic [AW-1:0] e_addr);
    vec_t v;
    v.rst_n = r; v.ird = ird; v.drd = drd; v.dwr = dwr; v.resp = resp; v.daddr = daddr;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr; v.e_addr = e_addr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [LW-1:0] wline;
    wline = {32{8'hA5}};
    rst_n = 1'b0; i_pmem_read = 1'b0; i_pmem_addr = IA;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = DA; d_pmem_wdata = wline;
    mem_rdata = '0; mem_resp = 1'b0;

    //   rst ird drd dwr rsp daddr   rd wr ir dr addr
    add(0, 0, 0, 0, 0, DA,   0, 0, 0, 0, IA);  // in reset
    add(1, 1, 0, 0, 0, DA,   0, 0, 0, 0, IA);  // I request seen in IDLE
    add(1, 1, 0, 0, 0, DA,   1, 0, 0, 0, IA);  // I_BUSY, first mem_read cycle
    add(1, 1, 0, 0, 0, DA,   1, 0, 0, 0, IA);
    add(1, 1, 0, 0, 0, DA,   1, 0, 0, 0, IA);
    add(1, 1, 0, 0, 1, DA,   1, 0, 1, 0, IA);  // resp 3 cycles after mem_read
    add(1, 0, 0, 0, 0, DA,   0, 0, 0, 0, IA);  // idle bubble
    add(1, 0, 0, 1, 0, DA,   0, 0, 0, 0, IA);  // D write-back request
    add(1, 0, 0, 1, 0, DA,   0, 1, 0, 0, DA);
    add(1, 0, 0, 1, 1, DA,   0, 1, 0, 1, DA);
    add(1, 0, 1, 0, 0, DB,   0, 0, 0, 0, IA);  // refill waits out the bubble
    add(1, 0, 1, 0, 1, DB,   1, 0, 0, 1, DB);
    add(1, 0, 0, 0, 0, DB,   0, 0, 0, 0, IA);
    add(1, 0, 0, 0, 1, DB,   0, 0, 0, 0, IA);  // stray resp in IDLE
    add(1, 0, 0, 0, 0, DB,   0, 0, 0, 0, IA);
    add(1, 0, 1, 1, 0, DA,   0, 0, 0, 0, IA);  // read+write together
    add(1, 0, 1, 1, 0, DA,   0, 1, 0, 0, DA);
    add(1, 0, 1, 1, 1, DA,   0, 1, 0, 1, DA);  // last grant now D
    add(1, 1, 1, 0, 0, DB,   0, 0, 0, 0, IA);  // simultaneous requests
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    add(1, 1, 1, 0, 1, DB,   1, 0, 1, 0, IA);  // I wins the tie
    add(1, 0, 1, 0, 0, DB,   0, 0, 0, 0, IA);
    add(1, 0, 1, 0, 1, DB,   1, 0, 0, 1, DB);
`else
    add(1, 1, 1, 0, 1, DB,   1, 0, 0, 1, DB);  // D wins the tie
    add(1, 1, 0, 0, 0, DB,   0, 0, 0, 0, IA);
    add(1, 1, 0, 0, 1, DB,   1, 0, 1, 0, IA);
`endif
    add(1, 0, 0, 0, 0, DB,   0, 0, 0, 0, IA);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; i_pmem_read = vq[i].ird;
      d_pmem_read = vq[i].drd; d_pmem_write = vq[i].dwr;
      d_pmem_addr = vq[i].daddr; mem_resp = vq[i].resp;
      mem_rdata = {8{32'hC0DE_0000 + 32'(i)}};
      #1;
      chk($sformatf("row%0d_ctl", i),
          {{(LW-AW-4){1'b0}}, mem_read, mem_write, i_pmem_resp, d_pmem_resp, mem_addr},
          {{(LW-AW-4){1'b0}}, vq[i].e_rd, vq[i].e_wr, vq[i].e_ir, vq[i].e_dr, vq[i].e_addr});
      if (vq[i].e_ir) chk($sformatf("row%0d_irdata", i), i_pmem_rdata, {8{32'hC0DE_0000 + 32'(i)}});
      if (vq[i].e_dr) chk($sformatf("row%0d_drdata", i), d_pmem_rdata, {8{32'hC0DE_0000 + 32'(i)}});
      if (vq[i].e_wr) chk($sformatf("row%0d_wdata", i), mem_wdata, wline);
    end

    // Async reset in the middle of a D write-back.
    @(negedge clk);
    d_pmem_write = 1'b1; d_pmem_addr = DA; mem_resp = 1'b0;
    @(negedge clk); #1;
    chk("rst_pre_write", {{(LW-1){1'b0}}, mem_write}, {{(LW-1){1'b0}}, 1'b1});
    #2; rst_n = 1'b0; mem_resp = 1'b1; #1;
    chk("rst_async_ctl", {{(LW-4){1'b0}}, mem_read, mem_write, i_pmem_resp, d_pmem_resp}, '0);
    @(negedge clk);
    rst_n = 1'b1; d_pmem_write = 1'b0; mem_resp = 1'b1; #1;
    chk("rst_stray_resp", {{(LW-4){1'b0}}, mem_read, mem_write, i_pmem_resp, d_pmem_resp}, '0);
    @(negedge clk);
    mem_resp = 1'b0; i_pmem_read = 1'b1; d_pmem_read = 1'b1; #1;
    chk("rst_idle", {{(LW-4){1'b0}}, mem_read, mem_write, i_pmem_resp, d_pmem_resp}, '0);
    // last_grant back to I after reset, so a tie goes to D under either policy.
    @(negedge clk); #1;
    chk("rst_tie_grant", {{(LW-AW-2){1'b0}}, mem_read, mem_write, mem_addr},
        {{(LW-AW-2){1'b0}}, 1'b1, 1'b0, DA});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
